// File: rtl/batch_sequencer_if.sv
// Sample stream from input_buffer into the sequencer and the re-timed,
// run-tagged stream it forwards to the spectral stage.
interface batch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned RUN_WIDTH  = 2
);
    logic                  in_valid;
    logic                  in_sop;
    logic                  in_eop;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_sop;
    logic                  out_eop;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RUN_WIDTH-1:0]  out_run;

    // master is the buffer/consumer side, slave is the sequencer itself
    modport master (
        output in_valid, in_sop, in_eop, in_data,
        input  out_valid, out_sop, out_eop, out_data, out_run
    );
    modport slave (
        input  in_valid, in_sop, in_eop, in_data,
        output out_valid, out_sop, out_eop, out_data, out_run
    );
endinterface

// File: rtl/batch_sequencer.sv
// Arms input_buffer, checks and re-times RUNS batches of BATCH_SIZE samples,
// tags each beat with its run index and optionally re-arms after a holdoff.
module batch_sequencer #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned BATCH_SIZE = 2048,
    parameter int unsigned RUNS       = 3,
    parameter int unsigned HOLDOFF    = 1024,
    parameter int unsigned TIMEOUT    = 65536,
    parameter int unsigned RUN_WIDTH  = (RUNS > 1) ? $clog2(RUNS) : 1
) (
    input  logic             source_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto,
    input  logic             abort,
    input  logic             err_clr,
    batch_sequencer_if.slave stream,
    output logic             buf_arm,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err
);

    localparam int unsigned CNT_W  = $clog2(BATCH_SIZE + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [CNT_W-1:0]     LAST_SAMPLE = CNT_W'(BATCH_SIZE);
    localparam logic [WAIT_W-1:0]    WAIT_LIMIT  = WAIT_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0]    HOLD_LIMIT  = HOLD_W'(HOLDOFF);
    localparam logic [RUN_WIDTH-1:0] RUN_LAST    = RUN_WIDTH'(RUNS - 1);

    typedef enum logic [2:0] {
        stIdle,
        stArm,
        stWaitSop,
        stStream,
        stNext,
        stHoldoff
    } state_t;

    state_t               state, stateNext;
    logic [RUN_WIDTH-1:0] runCnt, runNext;
    logic [CNT_W-1:0]     sampleCnt, sampleNext;
    logic [WAIT_W-1:0]    waitCnt, waitNext;
    logic [HOLD_W-1:0]    holdCnt, holdNext;
    logic [2:0]           errSet;
    logic                 fwd, fwdSop, fwdEop;
    logic                 armNext, doneNext;

    always_comb begin
        stateNext  = state;
        runNext    = runCnt;
        sampleNext = sampleCnt;
        waitNext   = waitCnt;
        holdNext   = holdCnt;
        errSet     = '0;
        fwd        = 1'b0;
        fwdSop     = 1'b0;
        fwdEop     = 1'b0;
        armNext    = 1'b0;
        doneNext   = 1'b0;

        unique case (state)
            stIdle: begin
                errSet[0] = stream.in_valid;
                if (start) stateNext = stArm;
            end
            stArm: begin
                errSet[0] = stream.in_valid;
                armNext   = 1'b1;
                runNext   = '0;
                waitNext  = '0;
                stateNext = stWaitSop;
            end
            stWaitSop: begin
                if (stream.in_valid && stream.in_sop) begin
                    fwd        = 1'b1;
                    fwdSop     = 1'b1;
                    sampleNext = CNT_W'(1);
                    errSet[1]  = stream.in_eop;
                    stateNext  = stStream;
                end else begin
                    errSet[0] = stream.in_valid;
                    if (waitCnt + WAIT_W'(1) == WAIT_LIMIT) begin
                        errSet[2] = 1'b1;
                        waitNext  = '0;
                        stateNext = stIdle;
                    end else begin
                        waitNext = waitCnt + WAIT_W'(1);
                    end
                end
            end
            stStream: begin
                if (stream.in_valid) begin
                    fwd        = 1'b1;
                    sampleNext = sampleCnt + CNT_W'(1);
                    if (stream.in_sop) errSet[1] = 1'b1;
                    // eop is regenerated from the count; in_eop only feeds the framing check
                    if (sampleNext == LAST_SAMPLE) begin
                        fwdEop    = 1'b1;
                        stateNext = stNext;
                        if (!stream.in_eop) errSet[1] = 1'b1;
                    end else if (stream.in_eop) begin
                        errSet[1] = 1'b1;
                    end
                end
            end
            stNext: begin
                errSet[0]  = stream.in_valid;
                sampleNext = '0;
                if (runCnt != RUN_LAST) begin
                    runNext   = runCnt + RUN_WIDTH'(1);
                    waitNext  = '0;
                    stateNext = stWaitSop;
                end else begin
                    doneNext  = 1'b1;
                    holdNext  = '0;
                    stateNext = auto ? stHoldoff : stIdle;
                end
            end
            stHoldoff: begin
                errSet[0] = stream.in_valid;
                if (!auto) begin
                    holdNext  = '0;
                    stateNext = stIdle;
                end else if (holdCnt + HOLD_W'(1) == HOLD_LIMIT) begin
                    holdNext  = '0;
                    stateNext = stArm;
                end else begin
                    holdNext = holdCnt + HOLD_W'(1);
                end
            end
            default: stateNext = stIdle;
        endcase

        // abort overrides everything: the beat in this cycle is discarded, not flagged
        if (abort) begin
            stateNext = stIdle;
            errSet    = '0;
            fwd       = 1'b0;
            fwdSop    = 1'b0;
            fwdEop    = 1'b0;
            armNext   = 1'b0;
            doneNext  = 1'b0;
        end
    end

    always_ff @(posedge source_clk) begin
        if (!reset) begin
            state            <= stIdle;
            runCnt           <= '0;
            sampleCnt        <= '0;
            waitCnt          <= '0;
            holdCnt          <= '0;
            err              <= '0;
            buf_arm          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_sop   <= 1'b0;
            stream.out_eop   <= 1'b0;
            stream.out_data  <= '0;
            stream.out_run   <= '0;
        end else begin
            state            <= stateNext;
            runCnt           <= runNext;
            sampleCnt        <= sampleNext;
            waitCnt          <= waitNext;
            holdCnt          <= holdNext;
            err              <= (err & ~{3{err_clr}}) | errSet;
            buf_arm          <= armNext;
            busy             <= (stateNext != stIdle);
            done             <= doneNext;
            stream.out_valid <= fwd;
            stream.out_sop   <= fwdSop;
            stream.out_eop   <= fwdEop;
            if (fwd) begin
                stream.out_data <= stream.in_data;
                stream.out_run  <= runCnt;
            end
        end
    end

endmodule

// File: tb/tb_batch_sequencer.sv
// Randomized bench for batch_sequencer: expected beats, arm/done cycles and
// error flags are derived from the batch-level sequencing rules.
module tb_batch_sequencer;

    localparam int unsigned DW = 14;
    localparam int unsigned BS = 8;
    localparam int unsigned NR = 3;
    localparam int unsigned HO = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned RW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [RW-1:0] run;
        int unsigned   at;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic auto = 1'b0;
    logic abort = 1'b0;
    logic errClr = 1'b0;
    logic bufArm, busy, done;
    logic [2:0] err;

    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned strayFlags = 0;
    int unsigned lastBeatCyc = 0;
    logic [2:0] expErr = '0;

    beat_t       obsBeats[$], expBeats[$];
    int unsigned obsArm[$], expArm[$], obsDone[$], expDone[$];

    batch_sequencer_if #(.DATA_WIDTH(DW), .RUN_WIDTH(RW)) bus ();

    batch_sequencer #(
        .DATA_WIDTH(DW), .BATCH_SIZE(BS), .RUNS(NR),
        .HOLDOFF(HO), .TIMEOUT(TO), .RUN_WIDTH(RW)
    ) dut (
        .source_clk(clk), .reset(reset), .start(start), .auto(auto),
        .abort(abort), .err_clr(errClr), .stream(bus),
        .buf_arm(bufArm), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid)
            obsBeats.push_back(beat_t'{bus.out_data, bus.out_sop, bus.out_eop, bus.out_run, cyc});
        else if (bus.out_sop || bus.out_eop)
            strayFlags++;
        if (bufArm) obsArm.push_back(cyc);
        if (done) obsDone.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic clearAll();
        obsBeats.delete(); expBeats.delete();
        obsArm.delete();   expArm.delete();
        obsDone.delete();  expDone.delete();
        expErr = '0;
    endtask

    // start is seen in IDLE at the next edge; the arm cycle follows, and buf_arm is registered out of it
    task automatic pulseStart();
        start = 1'b1;
        expArm.push_back(cyc + 2);
        tick();
        start = 1'b0;
    endtask

    // One batch; eopBeat = beat carrying in_eop (0 = none), abortBeat = beat carrying abort (0 = none)
    task automatic sendBatch(input int unsigned run, input int unsigned eopBeat, input int unsigned abortBeat);
        logic [DW-1:0] d;
        idle(1 + $urandom_range(0, 2));
        if (eopBeat != BS) expErr[1] = 1'b1;
        for (int unsigned i = 1; i <= BS; i++) begin
            d = DW'($urandom);
            bus.in_valid = 1'b1;
            bus.in_sop   = (i == 1);
            bus.in_eop   = (i == eopBeat);
            bus.in_data  = d;
            if (i == abortBeat) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
                return;
            end
            expBeats.push_back(beat_t'{d, i == 1, i == BS, RW'(run), cyc + 1});
            lastBeatCyc = cyc;
            tick();
            bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
            if (i < BS) idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(2);
        checks++;
        if ({bufArm, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got arm=%b busy=%b done=%b err=%b required all 0", bufArm, busy, done, err);
        end
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_run, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_stream: got v=%b sop=%b eop=%b run=%0d data=%h required all 0",
                     bus.out_valid, bus.out_sop, bus.out_eop, bus.out_run, bus.out_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        clearAll();
        auto = 1'b0;
        pulseStart();
        for (int unsigned r = 0; r < NR; r++) sendBatch(r, BS, 0);
        expDone.push_back(lastBeatCyc + 2);
        idle(6);
        checks++;
        if (obsBeats.size() != expBeats.size()) begin
            errors++;
            $display("FAIL nominal_count: got %0d beats required %0d", obsBeats.size(), expBeats.size());
        end
        for (int i = 0; i < expBeats.size() && i < obsBeats.size(); i++) begin
            checks++;
            if (obsBeats[i] !== expBeats[i]) begin
                errors++;
                $display("FAIL nominal_beat%0d: got %h required %h", i, obsBeats[i], expBeats[i]);
            end
        end
        checks++;
        if (obsArm.size() != 1 || obsArm[0] != expArm[0]) begin
            errors++;
            $display("FAIL nominal_arm: got %0d pulses first at %0d required 1 at %0d",
                     obsArm.size(), obsArm.size() ? obsArm[0] : 0, expArm[0]);
        end
        checks++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            errors++;
            $display("FAIL nominal_done: got %0d pulses first at %0d required 1 at %0d",
                     obsDone.size(), obsDone.size() ? obsDone[0] : 0, expDone[0]);
        end
        checks++;
        if (busy !== 1'b0 || err !== expErr) begin
            errors++;
            $display("FAIL nominal_idle: got busy=%b err=%b required busy=0 err=%b", busy, err, expErr);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== expBeats[expBeats.size()-1].data) begin
            errors++;
            $display("FAIL nominal_hold: got v=%b data=%h required v=0 data=%h",
                     bus.out_valid, bus.out_data, expBeats[expBeats.size()-1].data);
        end
        checks++;
        if (strayFlags != 0) begin
            errors++;
            $display("FAIL nominal_flags: got %0d sop/eop without valid required 0", strayFlags);
        end
    endtask

    task automatic test_auto();
        clearAll();
        auto = 1'b1;
        pulseStart();
        for (int unsigned r = 0; r < NR; r++) sendBatch(r, BS, 0);
        expDone.push_back(lastBeatCyc + 2);
        // done marks the first of HO holdoff cycles; the re-arm cycle then registers buf_arm
        expArm.push_back(lastBeatCyc + 2 + HO + 1);
        idle(HO + 1);
        for (int unsigned r = 0; r < NR; r++) sendBatch(r, BS, 0);
        expDone.push_back(lastBeatCyc + 2);
        idle(2);
        auto = 1'b0;
        idle(20);
        checks++;
        if (obsBeats.size() != expBeats.size()) begin
            errors++;
            $display("FAIL auto_count: got %0d beats required %0d", obsBeats.size(), expBeats.size());
        end
        for (int i = 0; i < expBeats.size() && i < obsBeats.size(); i++) begin
            checks++;
            if (obsBeats[i] !== expBeats[i]) begin
                errors++;
                $display("FAIL auto_beat%0d: got %h required %h", i, obsBeats[i], expBeats[i]);
            end
        end
        checks++;
        if (obsArm.size() != 2) begin
            errors++;
            $display("FAIL auto_arm_count: got %0d pulses required 2", obsArm.size());
        end
        for (int i = 0; i < 2 && i < obsArm.size(); i++) begin
            checks++;
            if (obsArm[i] != expArm[i]) begin
                errors++;
                $display("FAIL auto_arm%0d: got cycle %0d required %0d", i, obsArm[i], expArm[i]);
            end
        end
        checks++;
        if (obsDone.size() != 2 || obsDone[0] != expDone[0] || obsDone[1] != expDone[1]) begin
            errors++;
            $display("FAIL auto_done: got %0d pulses required 2 at %0d,%0d", obsDone.size(), expDone[0], expDone[1]);
        end
        checks++;
        if (busy !== 1'b0 || err !== expErr) begin
            errors++;
            $display("FAIL auto_idle: got busy=%b err=%b required busy=0 err=%b", busy, err, expErr);
        end
    endtask

    task automatic test_framing();
        clearAll();
        pulseStart();
        sendBatch(0, 5, 0);
        sendBatch(1, 0, 0);
        sendBatch(2, BS, 0);
        expDone.push_back(lastBeatCyc + 2);
        idle(5);
        checks++;
        if (obsBeats.size() != expBeats.size()) begin
            errors++;
            $display("FAIL framing_count: got %0d beats required %0d", obsBeats.size(), expBeats.size());
        end
        for (int i = 0; i < expBeats.size() && i < obsBeats.size(); i++) begin
            checks++;
            if (obsBeats[i] !== expBeats[i]) begin
                errors++;
                $display("FAIL framing_beat%0d: got %h required %h", i, obsBeats[i], expBeats[i]);
            end
        end
        checks++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0]) begin
            errors++;
            $display("FAIL framing_done: got %0d pulses required 1 at %0d", obsDone.size(), expDone[0]);
        end
        checks++;
        if (err !== expErr) begin
            errors++;
            $display("FAIL framing_err: got %b required %b", err, expErr);
        end
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checks++;
        if (err !== 3'b000) begin
            errors++;
            $display("FAIL framing_clear: got %b required 000", err);
        end
    endtask

    task automatic test_timeout();
        clearAll();
        pulseStart();
        // WAIT_SOP is entered two edges after start; it gives up after TO cycles there
        idle(TO);
        checks++;
        if (err !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err=%b busy=%b required err=000 busy=1", err, busy);
        end
        tick();
        checks++;
        if (err !== 3'b100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: got err=%b busy=%b required err=100 busy=0", err, busy);
        end
        idle(2);
        bus.in_valid = 1'b1; bus.in_data = DW'($urandom);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (err !== 3'b101) begin
            errors++;
            $display("FAIL stray_idle: got err=%b required 101", err);
        end
        bus.in_valid = 1'b1; errClr = 1'b1;
        tick();
        bus.in_valid = 1'b0; errClr = 1'b0;
        checks++;
        if (err !== 3'b001) begin
            errors++;
            $display("FAIL clear_vs_set: got err=%b required 001", err);
        end
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        idle(2);
        checks++;
        if (err !== 3'b000) begin
            errors++;
            $display("FAIL timeout_clear: got err=%b required 000", err);
        end
        checks++;
        if (obsBeats.size() != 0 || obsDone.size() != 0 || obsArm.size() != 1 || obsArm[0] != expArm[0]) begin
            errors++;
            $display("FAIL timeout_events: got beats=%0d done=%0d arm=%0d required 0/0/1 at %0d",
                     obsBeats.size(), obsDone.size(), obsArm.size(), expArm[0]);
        end
    endtask

    task automatic test_abort();
        clearAll();
        pulseStart();
        sendBatch(0, BS, 0);
        sendBatch(1, BS, 4);
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: got busy=%b valid=%b required 0/0", busy, bus.out_valid);
        end
        idle(6);
        checks++;
        if (obsBeats.size() != expBeats.size() || obsDone.size() != 0) begin
            errors++;
            $display("FAIL abort_events: got beats=%0d done=%0d required %0d/0",
                     obsBeats.size(), obsDone.size(), expBeats.size());
        end
        for (int i = 0; i < expBeats.size() && i < obsBeats.size(); i++) begin
            checks++;
            if (obsBeats[i] !== expBeats[i]) begin
                errors++;
                $display("FAIL abort_beat%0d: got %h required %h", i, obsBeats[i], expBeats[i]);
            end
        end
        clearAll();
        pulseStart();
        for (int unsigned r = 0; r < NR; r++) sendBatch(r, BS, 0);
        expDone.push_back(lastBeatCyc + 2);
        idle(4);
        checks++;
        if (obsBeats.size() != expBeats.size()) begin
            errors++;
            $display("FAIL rerun_count: got %0d beats required %0d", obsBeats.size(), expBeats.size());
        end
        for (int i = 0; i < expBeats.size() && i < obsBeats.size(); i++) begin
            checks++;
            if (obsBeats[i] !== expBeats[i]) begin
                errors++;
                $display("FAIL rerun_beat%0d: got %h required %h", i, obsBeats[i], expBeats[i]);
            end
        end
        checks++;
        if (obsDone.size() != 1 || obsDone[0] != expDone[0] || obsArm.size() != 1 || obsArm[0] != expArm[0]) begin
            errors++;
            $display("FAIL rerun_events: got done=%0d arm=%0d required 1 at %0d / 1 at %0d",
                     obsDone.size(), obsArm.size(), expDone[0], expArm[0]);
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] d;
        clearAll();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (err !== 3'b001) begin
            errors++;
            $display("FAIL rst_pre: got err=%b required 001", err);
        end
        pulseStart();
        idle(1);
        for (int unsigned i = 1; i <= BS; i++) begin
            d = DW'($urandom);
            bus.in_valid = 1'b1; bus.in_sop = (i == 1); bus.in_eop = (i == BS); bus.in_data = d;
            if (i < 4) expBeats.push_back(beat_t'{d, i == 1, 1'b0, RW'(0), cyc + 1});
            if (i == 4) reset = 1'b0;
            tick();
            if (i == 4) begin
                checks++;
                if ({bufArm, busy, done, err, bus.out_valid, bus.out_sop, bus.out_eop,
                     bus.out_run, bus.out_data} !== '0) begin
                    errors++;
                    $display("FAIL rst_mid: got arm=%b busy=%b done=%b err=%b v=%b run=%0d data=%h required all 0",
                             bufArm, busy, done, err, bus.out_valid, bus.out_run, bus.out_data);
                end
                reset = 1'b1;
            end
        end
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        idle(3);
        checks++;
        if (err !== 3'b001 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got err=%b busy=%b required err=001 busy=0", err, busy);
        end
        checks++;
        if (obsBeats.size() != expBeats.size() || obsDone.size() != 0) begin
            errors++;
            $display("FAIL rst_events: got beats=%0d done=%0d required %0d/0",
                     obsBeats.size(), obsDone.size(), expBeats.size());
        end
        for (int i = 0; i < expBeats.size() && i < obsBeats.size(); i++) begin
            checks++;
            if (obsBeats[i] !== expBeats[i]) begin
                errors++;
                $display("FAIL rst_beat%0d: got %h required %h", i, obsBeats[i], expBeats[i]);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_nominal();
        test_auto();
        test_framing();
        test_timeout();
        test_abort();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/batch_sequencer.md
Name: batch_sequencer

Overview:
- Single-clock controller in the source_clk domain that sequences input_buffer.
- Arms one capture, then expects RUNS batches of BATCH_SIZE samples on the buffer's sop/eop/valid stream.
- Checks the stream's framing, re-times it, tags each batch with a run index, and signals sequence completion.
- Optional auto mode re-arms after a programmable holdoff, giving continuous acquisition for the downstream spectral stage.

Parameters:
DATA_WIDTH, 14, sample width
BATCH_SIZE, 2048, samples per batch (>=2)
RUNS, 3, batches per armed sequence (>=1)
HOLDOFF, 1024, idle cycles between sequences in auto mode (>=1)
TIMEOUT, 65536, max cycles waiting for a batch sop before abort-with-error

Ports:
source_clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  begin a sequence (level; sampled in IDLE only)
auto  in  1  1 = re-arm after HOLDOFF when a sequence completes
abort  in  1  terminate the current sequence
err_clr  in  1  clear sticky error flags
in_valid  in  1  buffer stream valid
in_sop  in  1  buffer stream start of packet
in_eop  in  1  buffer stream end of packet
in_data  in  DATA_WIDTH  buffer stream data
buf_arm  out  1  one-cycle pulse requesting a capture from input_buffer
out_valid  out  1  re-timed stream valid
out_sop  out  1  regenerated sop
out_eop  out  1  regenerated eop
out_data  out  DATA_WIDTH  re-timed data
out_run  out  max(1,$clog2(RUNS))  run index of the current out beat
busy  out  1  1 in any state except IDLE
done  out  1  one-cycle pulse after the last beat of run RUNS-1
err  out  3  sticky: [0] stray beat, [1] framing, [2] timeout

Behaviour:
- Reset (reset==0 at an edge): state IDLE; all outputs 0; counters 0; err cleared.
- States: IDLE, ARM, WAIT_SOP, STREAM, NEXT, HOLDOFF.
- IDLE: busy=0; start=1 -> ARM.
- ARM: buf_arm=1 for exactly one cycle; run=0; -> WAIT_SOP.
- WAIT_SOP:
  - Wait counter increments each cycle.
  - in_valid&in_sop -> STREAM; that beat is forwarded with out_sop=1 and sample count=1.
  - in_valid without in_sop -> beat dropped, err[0] set.
  - Wait counter reaching TIMEOUT -> err[2] set, -> IDLE, no done.
- STREAM:
  - Each in_valid beat is forwarded and the count increments.
  - out_eop=1 is generated on the BATCH_SIZE-th beat regardless of in_eop; then -> NEXT.
  - Framing error err[1] is set for any of:
    - in_eop on a beat other than the BATCH_SIZE-th;
    - in_eop absent on the BATCH_SIZE-th beat;
    - in_sop on a non-first beat.
  - The offending beat is still forwarded as data.
  - in_valid=0 cycles are allowed; no timeout applies inside a batch.
- NEXT (one cycle):
  - run<RUNS-1: run++ and wait counter cleared; -> WAIT_SOP.
  - Otherwise: done=1; -> HOLDOFF if auto, else IDLE.
- HOLDOFF:
  - Counts HOLDOFF cycles, then -> ARM.
  - auto deasserted at any point -> IDLE.
  - start is ignored here.
- Latency: out_* is registered exactly 1 cycle after the corresponding in_* beat.
  - out_run holds the run of that beat.
  - out_valid=0 and out_sop/out_eop=0 on non-beat cycles.
  - out_data holds its last value when out_valid=0.
- Beats arriving in IDLE, ARM, NEXT or HOLDOFF: dropped, err[0] set, never forwarded.
- abort:
  - From any state, the next state is IDLE.
  - The beat presented in the abort cycle is discarded.
  - No done; out_valid=0 from the following cycle.
  - abort has priority over start and over all state transitions.
- start while busy: ignored.
- err: each bit sets independently and stays set until err_clr. If set and clear coincide in one cycle, set wins. err does not affect sequencing.
- Widths: the sample counter holds 0..BATCH_SIZE; the wait counter holds 0..TIMEOUT; the holdoff counter holds 0..HOLDOFF. No wrap-around is permitted.

Test Plan:
Use BATCH_SIZE=8, RUNS=3, HOLDOFF=4, TIMEOUT=16.
1. Nominal sequence. Stimulus: reset low 2 cycles, then start=1 for 1 cycle, auto=0; stream 3 clean 8-beat batches with gaps. Required: buf_arm pulses once, 2 cycles after start sampled; 24 out beats, each 1 cycle late; out_sop on beats 1/9/17, out_eop on 8/16/24; out_run 0,0..1..2; single done after beat 24; busy returns 0; err=000.
2. Auto mode. Stimulus: auto=1 held, clean streams. Required: after done, exactly 4 HOLDOFF cycles, then buf_arm again; drop auto during the second holdoff -> IDLE, no further buf_arm.
3. Framing errors. Stimulus: in_eop on beat 5 of run 0; missing eop on beat 8 of run 1. Required: err[1]=1; out_eop still only on beats 8/16/24; all 24 beats forwarded; done still pulses.
4. Timeout and stray beat. Stimulus: start with no stream for 16 cycles -> err[2]=1, IDLE, no done. Then a valid beat in IDLE -> err[0]=1, out_valid stays 0. err_clr asserted together with a new stray beat -> err[0] remains 1.
5. Abort mid-batch. Stimulus: abort on beat 4 of run 1. Required: IDLE next cycle; no out_valid after that cycle; done never pulses; a new start runs a full clean sequence.
6. Reset mid-stream. Stimulus: reset=0 during STREAM for 1 cycle. Required: all outputs 0 at the next edge; err=000; the remainder of the stream counts as stray beats (err[0]=1 after reset is released).
